step_scroller: RTL

STEP_SCROLLER -- requirements
Module: step_scroller

---
 rtl/step_scroller.sv | 129 ++++++++++++
 1 files changed

// File: rtl/step_scroller.sv
// step_scroller: debounced push-button / auto-timer stepper that scrolls a
// 16-character hex message across eight 5-bit character slots.
// Slot k of char_bus carries ROM[(pointer+k) mod 16] and drives digit an(7-k).
module step_scroller #(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
   parameter logic [23:0] AUTO_PERIOD     = 24'd10000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        step_button,
   input  logic        auto_en,
   output logic [39:0] char_bus,
   output logic [3:0]  msg_pos,
   output logic        step_pulse
);

   // Message ROM: entry i holds the hex digit i.
   function automatic logic [4:0] rom_char(input logic [3:0] addr);
      return {1'b0, addr};
   endfunction

   // Eight consecutive ROM entries starting at base, slot k in bits [5k+4:5k].
   function automatic logic [39:0] build_word(input logic [3:0] base);
      logic [39:0] word;
      logic [3:0]  idx;
      word = 40'd0;
      for (int k = 0; k < 8; k++) begin
         idx = base + 4'(k);
         word[5*k +: 5] = rom_char(idx);
      end
      return word;
   endfunction

   localparam logic [39:0] RESET_WORD = build_word(4'd0);

   logic        sync1_q, sync2_q;
   logic        deb_q, deb_d;
   logic [15:0] db_cnt_q, db_cnt_d;
   logic [23:0] auto_cnt_q, auto_cnt_d;
   logic        pulse_q, pulse_d;
   logic [3:0]  ptr_q, ptr_d;
   logic [39:0] bus_q, bus_d;
   logic        rise_s;
   logic        auto_tick_s;

   // Two-flop synchronizer for the raw asynchronous button.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= step_button;
         sync2_q <= sync1_q;
      end
   end

   // Debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
   always_comb begin
      deb_d    = deb_q;
      db_cnt_d = 16'd0;
      if (sync2_q != deb_q) begin
         if (db_cnt_q == (DEBOUNCE_CYCLES - 16'd1)) begin
            deb_d    = sync2_q;
            db_cnt_d = 16'd0;
         end else begin
            db_cnt_d = db_cnt_q + 16'd1;
         end
      end else begin
         db_cnt_d = 16'd0;
      end
   end

   // A press is the debounced level going 0->1 on this edge; releases are ignored.
   always_comb begin
      rise_s = deb_d & ~deb_q;
   end

   // Auto timer: free-runs 0..AUTO_PERIOD-1 while enabled, parked at 0 otherwise.
   always_comb begin
      auto_cnt_d  = 24'd0;
      auto_tick_s = 1'b0;
      if (auto_en) begin
         if (auto_cnt_q == (AUTO_PERIOD - 24'd1)) begin
            auto_cnt_d  = 24'd0;
            auto_tick_s = 1'b1;
         end else begin
            auto_cnt_d  = auto_cnt_q + 24'd1;
         end
      end else begin
         auto_cnt_d = 24'd0;
      end
   end

   // Step strobe merges press and tick (a coincidence is one step), the pointer
   // advances as the strobe ends, and the display word follows the pointer a cycle later.
   always_comb begin
      pulse_d = rise_s | auto_tick_s;
      if (pulse_q) begin
         ptr_d = ptr_q + 4'd1;
      end else begin
         ptr_d = ptr_q;
      end
      bus_d = build_word(ptr_q);
   end

   // State registers for debounce, timer, strobe, pointer and display word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         deb_q      <= 1'b0;
         db_cnt_q   <= 16'd0;
         auto_cnt_q <= 24'd0;
         pulse_q    <= 1'b0;
         ptr_q      <= 4'd0;
         bus_q      <= RESET_WORD;
      end else begin
         deb_q      <= deb_d;
         db_cnt_q   <= db_cnt_d;
         auto_cnt_q <= auto_cnt_d;
         pulse_q    <= pulse_d;
         ptr_q      <= ptr_d;
         bus_q      <= bus_d;
      end
   end

   assign char_bus   = bus_q;
   assign msg_pos    = ptr_q;
   assign step_pulse = pulse_q;

endmodule
